registro_pipeline_elastico: RTL and testbench
=============================================

REGISTRO_PIPELINE_ELASTICO -- requirements
Module: registro_pipeline_elastico

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 Parameter STAGES, default 3, number of register stages (>=1).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 flush  input  1  synchronous clear of all stage valid bits.
REQ-006 in_valid  input  1  upstream word present on in_data.
REQ-007 in_data  input  WIDTH  upstream word.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_data  output  WIDTH  downstream word.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 occupancy  output  $clog2(STAGES+1)  count of valid stages.

Function
REQ-013 The block SHALL hold STAGES stages, index 0 (input side) to STAGES-1 (output side), each a WIDTH data register plus a valid bit v[k].
REQ-014 out_valid SHALL equal v[STAGES-1] and out_data SHALL equal the data register of stage STAGES-1.
REQ-015 Stage ready SHALL be combinational: rdy[STAGES-1] = !v[STAGES-1] | out_ready; rdy[k] = !v[k] | rdy[k+1] for k < STAGES-1.
REQ-016 in_ready SHALL equal rdy[0] & !flush.
REQ-017 Transfer on each side SHALL occur only on a clock edge where valid and ready are both 1.
REQ-018 When flush=0 and rdy[k]=1, v[k] SHALL load the upstream valid: in_valid for k=0, v[k-1] for k>0.
REQ-019 When flush=0 and rdy[k]=1 and the upstream valid is 1, stage k data SHALL load upstream data; otherwise the data register SHALL hold its value.
REQ-020 When rdy[k]=0, stage k valid and data SHALL hold.
REQ-021 Empty stages SHALL be filled regardless of downstream stall (bubble collapse); a stall blocks in_ready only when all STAGES stages are valid and out_ready=0.
REQ-022 Unstalled latency SHALL be exactly STAGES cycles from input transfer to out_valid=1 with that word; throughput SHALL be one word per cycle.
REQ-023 Word order SHALL be preserved; no word shall be lost or duplicated.
REQ-024 flush=1 SHALL clear every v[k] on the next edge, override in_valid and out_ready, and leave data registers unchanged; out_valid stays combinationally unchanged during the flush cycle, so a word with out_valid & out_ready in that cycle counts as transferred.
REQ-025 occupancy SHALL be the combinational population count of v[0..STAGES-1].
REQ-026 With STAGES=1, the block SHALL act as a single elastic register: in_ready = (!v[0] | out_ready) & !flush.

Reset
REQ-027 reset=1 SHALL immediately clear all v[k] and all data registers to 0, independent of clk, including mid-transfer.
REQ-028 During and after reset: out_valid=0, out_data=0, occupancy=0, in_ready=1 (flush=0).
REQ-029 The first transfer after reset release SHALL occur on the first rising edge with reset=0.

Verification (WIDTH=8, STAGES=3)
REQ-030 Reset: assert reset mid-stream -> out_valid=0, out_data=0x00, occupancy=0, in_ready=1 without waiting for a clock edge.
REQ-031 Streaming: 0x11,0x22,0x33,0x44 on consecutive edges, out_ready=1 -> 0x11 at output 3 cycles after acceptance, then one word per cycle in order, in_ready constantly 1.
REQ-032 Backpressure: out_ready=0, offer 0x11..0x44 -> first three accepted, in_ready=0 while 0x44 waits, occupancy=3; raise out_ready -> 0x11,0x22,0x33,0x44 delivered in order, no duplicates.
REQ-033 Bubble collapse: one word 0xA5 with out_ready=0 -> reaches stage 2 after 3 edges, occupancy=1, in_ready stays 1; 0x5A then accepted and fills stage 1.
REQ-034 Flush: pipeline full, flush=1 with in_valid=1 and in_data=0x77 -> in_ready=0 that cycle, next cycle occupancy=0, out_valid=0, 0x77 never emerges.
REQ-035 Simultaneous push/pop when full: occupancy=3, in_valid=1, out_ready=1 -> in_ready=1, one word out, one in, occupancy stays 3.

Source files
------------

// File: rtl/registro_pipeline_elastico.sv
// Elastic register pipeline of STAGES valid/ready stages with bubble collapse and flush.
// Latency STAGES cycles unstalled, one word per cycle; empty stages keep filling under a downstream stall.
module registro_pipeline_elastico #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        out_ready,
  output logic [$clog2(STAGES+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(STAGES+1);

  logic [STAGES-1:0]            v;
  logic [STAGES-1:0]            rdy;
  logic [STAGES-1:0]            up_v;
  logic [STAGES-1:0][WIDTH-1:0] data;
  logic [STAGES-1:0][WIDTH-1:0] up_d;

  // Ready ripples from the output side; a running term avoids a self-referencing vector.
  always_comb begin
    logic r;
    rdy = '0;
    r   = !v[STAGES-1] | out_ready;
    rdy[STAGES-1] = r;
    for (int k = STAGES-2; k >= 0; k--) begin
      r      = !v[k] | r;
      rdy[k] = r;
    end
  end

  always_comb begin
    up_v    = '0;
    up_d    = '0;
    up_v[0] = in_valid;
    up_d[0] = in_data;
    for (int k = 1; k < STAGES; k++) begin
      up_v[k] = v[k-1];
      up_d[k] = data[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v    <= '0;
      data <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          v[k] <= up_v[k];
          if (up_v[k]) data[k] <= up_d[k];
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++)
      occupancy = occupancy + OCC_W'(v[k]);
  end

  assign in_ready  = rdy[0] & !flush;
  assign out_valid = v[STAGES-1];
  assign out_data  = data[STAGES-1];

endmodule

// File: tb/tb_registro_pipeline_elastico.sv
// Randomized + directed bench for registro_pipeline_elastico against a slot-position reference model.
module tb_registro_pipeline_elastico;

  localparam int W  = 8;
  localparam int S  = 3;
  localparam int OW = $clog2(S+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [OW-1:0] occupancy;

  int vectors = 0;
  int miscompares = 0;

  // Model: words in flight, oldest first, each with its stage position (S-1 = output).
  int           pos_q[$];
  logic [W-1:0] dat_q[$];

  registro_pipeline_elastico #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
    bit exp_rdy;
    bit exp_ov;
    int n;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    n       = pos_q.size();
    exp_rdy = !fl && (n < S || ordy);
    exp_ov  = 1'b0;
    if (n > 0) exp_ov = (pos_q[0] == S-1);
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
    check_eq("occupancy", 32'(occupancy), n);
    if (exp_ov) check_eq("out_data", 32'(out_data), 32'(dat_q[0]));
    if (fl) begin
      pos_q.delete();
      dat_q.delete();
    end else begin
      if (exp_ov && ordy) begin
        void'(pos_q.pop_front());
        void'(dat_q.pop_front());
      end
      // A word moves up when the sink drains, or when a gap exists somewhere above it.
      for (int i = 0; i < pos_q.size(); i++)
        if (ordy || (i < S-1-pos_q[i])) pos_q[i] = pos_q[i] + 1;
      if (iv && exp_rdy) begin
        pos_q.push_back(0);
        dat_q.push_back(id);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 0);
    check_eq({tag, "_out_data"},  32'(out_data), 0);
    check_eq({tag, "_occupancy"}, 32'(occupancy), 0);
    check_eq({tag, "_in_ready"},  32'(in_ready), 1);
  endtask

  task automatic reset_mid_stream();
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    pos_q.delete();
    dat_q.delete();
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst_init");
    @(negedge clk);
    reset = 1'b0;

    // Streaming at full rate.
    for (int i = 0; i < 4; i++) cycle(1'b1, W'(8'h11 * (i+1)), 1'b1, 1'b0);
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: 0x44 waits until a simultaneous push/pop on a full pipe.
    for (int i = 0; i < 4; i++) cycle(1'b1, W'(8'h11 * (i+1)), 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 8'h44, 1'b0, 1'b0);
    cycle(1'b1, 8'h44, 1'b1, 1'b0);
    repeat (5) cycle(1'b0, '0, 1'b1, 1'b0);

    // Bubble collapse under a stalled sink.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush of a full pipe with a word offered.
    for (int i = 0; i < 3; i++) cycle(1'b1, W'(8'hC1 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0);

    // Random traffic, with a flush in the mix and a reset partway through.
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) reset_mid_stream();
      cycle(1'($urandom_range(0, 3) != 0), W'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end
    repeat (5) cycle(1'b0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
